// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: row synchronizer, per-frame priority encode, frame debounce.
// Define KEYPAD_REPEAT_EN to compile in auto-repeat strobes every REPEAT_FRAMES frames.
module keypad_scanner #(
  parameter int SCAN_DIV      = 100000,
  parameter int DEBOUNCE_CNT  = 4,
  parameter int REPEAT_FRAMES = 250
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [4:0] key_code,
  output logic       key_valid
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [4:0]    NO_KEY     = 5'b11111;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } col_state_e;

  col_state_e    state_q, state_d, next_state;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    col_n_q, col_n_d;
  logic [3:0]    row_meta_q, row_sync_q;
  logic [4:0]    frame_q, frame_d;
  logic [4:0]    cand_q, cand_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [4:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic [4:0]    col_code, raw_code;
  logic          last_dwell, frame_end, accept;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_FRAMES);
  logic [RW-1:0] rep_q, rep_d;
`endif

  function automatic logic [4:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [4:0] code;
    case ({r, c})
      4'h0: code = 5'd1;
      4'h1: code = 5'd2;
      4'h2: code = 5'd3;
      4'h3: code = 5'd10;
      4'h4: code = 5'd4;
      4'h5: code = 5'd5;
      4'h6: code = 5'd6;
      4'h7: code = 5'd11;
      4'h8: code = 5'd7;
      4'h9: code = 5'd8;
      4'hA: code = 5'd9;
      4'hB: code = 5'd12;
      4'hC: code = 5'd0;
      4'hD: code = 5'd15;
      4'hE: code = 5'd14;
      default: code = 5'd13;
    endcase
    return code;
  endfunction

  always_comb begin
    col_code = NO_KEY;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync_q[r]) col_code = key_lookup(2'(r), state_q);
    end
    // A new frame starts at COL0; later columns only fill in if nothing was found yet
    raw_code   = (state_q == COL0 || frame_q == NO_KEY) ? col_code : frame_q;
    last_dwell = (dwell_q == DWELL_LAST);
    frame_end  = last_dwell && (state_q == COL3);
    next_state = col_state_e'(state_q + 2'd1);
    accept     = (stable_q == STABLE_MAX) && (cand_q != key_code_q);

    state_d     = state_q;
    dwell_d     = dwell_q + 1'b1;
    col_n_d     = col_n_q;
    frame_d     = frame_q;
    cand_d      = cand_q;
    stable_d    = stable_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;

    if (last_dwell) begin
      dwell_d = '0;
      state_d = next_state;
      col_n_d = ~(4'b0001 << next_state);
      frame_d = raw_code;
    end

    if (frame_end) begin
      if (raw_code == cand_q) begin
        if (stable_q != STABLE_MAX) stable_d = stable_q + 1'b1;
      end else begin
        cand_d   = raw_code;
        stable_d = SW'(1);
      end
    end

    // Acceptance is one cycle after the frame-end update, so key_code lags by +1 cycle
    if (accept) begin
      key_code_d  = cand_q;
      key_valid_d = (cand_q != NO_KEY);
    end

`ifdef KEYPAD_REPEAT_EN
    rep_d = rep_q;
    if (accept || key_code_q == NO_KEY) begin
      rep_d = '0;
    end else if (rep_q == REP_MAX) begin
      rep_d       = '0;
      key_valid_d = 1'b1;
    end else if (frame_end) begin
      rep_d = rep_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= COL0;
      dwell_q     <= '0;
      col_n_q     <= 4'b1110;
      row_meta_q  <= 4'b1111;
      row_sync_q  <= 4'b1111;
      frame_q     <= NO_KEY;
      cand_q      <= NO_KEY;
      stable_q    <= '0;
      key_code_q  <= NO_KEY;
      key_valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      col_n_q     <= col_n_d;
      row_meta_q  <= row_n;
      row_sync_q  <= row_meta_q;
      frame_q     <= frame_d;
      cand_q      <= cand_d;
      stable_q    <= stable_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Drives the column lines of the 4x4 PMOD keypad on JA and samples its row lines. Debounces the result and produces the 5-bit key code consumed by the calculator FSM. Codes 0-15 are keys; 5'b11111 means no key. It is the scanning end of the keypad interface that the top-level decode logic reads from. It replaces the free-running decode path with a debounced code plus a one-cycle new-key strobe.

Parameters:
SCAN_DIV, 100000, clk cycles each column is driven (dwell); must be >= 4
DEBOUNCE_CNT, 4, consecutive identical scan frames needed to accept a code change; must be >= 1
REPEAT_FRAMES, 250, frames between auto-repeat strobes (used only with KEYPAD_REPEAT_EN)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
col_n  output  4  column drive, active-low, exactly one bit low at all times
row_n  input  4  row sense, active-low, pulled up externally, asynchronous to clk
key_code  output  5  debounced key code, 5'b11111 = none
key_valid  output  1  one-cycle strobe when a new non-idle key_code is accepted

Behaviour:
- Reset (reset=0, async) values:
  - col_n=4'b1110 (column 0 driven)
  - key_code=5'b11111; key_valid=0
  - dwell counter, stable counter and candidate cleared; candidate=5'b11111
- Reset mid-scan restarts from column 0 and discards the partial frame.
- row_n passes through a 2-flop synchronizer before use.
- Column FSM, states COL0->COL1->COL2->COL3->COL0:
  - In COLc, col_n[c]=0 and all other bits are 1.
  - Each state lasts exactly SCAN_DIV cycles; frame = 4*SCAN_DIV cycles.
- Sampling: synchronized rows are sampled on the last dwell cycle of each column (settling margin of SCAN_DIV-1 cycles).
- Raw frame code, built over the frame:
  - Priority: first pressed key in scan order (col0 row0, col0 row1, ... col3 row3) wins.
  - No key in any column -> 5'b11111.
- Key map (row r, col c):
  - r0: 1, 2, 3, 10(add)
  - r1: 4, 5, 6, 11(sub)
  - r2: 7, 8, 9, 12(mul)
  - r3: 0, 15(mem), 14(equal), 13(div)
- Debounce, evaluated at each frame end (cycle the COL3 dwell expires):
  - raw==candidate: stable_cnt increments, saturating at DEBOUNCE_CNT.
  - Otherwise: candidate<=raw, stable_cnt<=1.
  - If stable_cnt (after update) ==DEBOUNCE_CNT and candidate!=key_code: key_code<=candidate on the next cycle.
  - key_valid pulses that same cycle, only if the new code !=5'b11111.
- Release (key->none) updates key_code with no strobe.
- Key-to-key change without an intervening release updates key_code and strobes.
- Latency: a press stable from the start of a frame appears on key_code DEBOUNCE_CNT frames later +1 cycle.
- Bounce shorter than DEBOUNCE_CNT frames never changes key_code.
- Holding a key produces exactly one strobe.
- key_valid is never high for two consecutive cycles.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - While key_code is a non-idle code, a frame counter runs.
  - Every REPEAT_FRAMES frames after acceptance, key_valid pulses again with the same key_code.
  - The counter clears on any key_code change or reset.
- Undefined: the repeat logic is not compiled; one strobe per accepted press.

Test Plan:
Parameters for all scenarios: SCAN_DIV=4, DEBOUNCE_CNT=2, frame=16 cycles. Keypad model: row_n[r]=col_n[c] when key (r,c) is held, else 1.
1. Reset release, no key -> col_n sequence 1110,1101,1011,0111 with 4 cycles each, repeating; key_code=5'b11111 and key_valid=0 throughout.
2. Hold (r1,c2) from a frame start -> after 2 frames +1 cycle key_code=6 with one key_valid pulse; no further pulses while held; release -> key_code=5'b11111 after 2 frames, no pulse.
3. (r3,c2) pressed for 1 frame, released 1 frame, pressed 1 frame (bounce) -> key_code stays 5'b11111, key_valid never asserted.
4. (r0,c3) and (r2,c1) held together -> key_code=8 (col1 scanned first), single pulse.
5. Hold (r0,c0), assert reset=0 mid-COL2 for 3 cycles -> col_n=1110 and key_code=5'b11111 immediately (async); after release key_code=1 with a pulse 2 frames +1 cycle later.
6. With KEYPAD_REPEAT_EN and REPEAT_FRAMES=3, hold (r3,c1) -> key_code=15; pulses at acceptance then every 48 cycles; without the macro, exactly one pulse.
